// File: rtl/pattern_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pattern_scan_ctrl_if
// Purpose  : Groups the configuration handshake, scan control, serial input
//            and status outputs of pattern_scan_ctrl into one bundle.
// Ports    : master - host side (drives cfg_*, start, abort, bit_valid, signal)
//            slave  - controller side (drives cfg_ready, cfg_err, out, busy,
//                     done, match_count)
// Revision : 1.0 - initial release
// ============================================================================
interface pattern_scan_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN) + 1;

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_limit;
  logic               cfg_err;
  logic               start;
  logic               abort;
  logic               bit_valid;
  logic               signal;
  logic               out;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_limit, start, abort,
           bit_valid, signal,
    input  cfg_ready, cfg_err, out, busy, done, match_count
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_limit, start, abort,
           bit_valid, signal,
    output cfg_ready, cfg_err, out, busy, done, match_count
  );
endinterface
`default_nettype wire

// File: rtl/pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pattern_scan_ctrl
// Purpose  : Reconfigurable overlapping Moore sequence detector for a serial
//            bit stream. Accepts pattern/length/limit over a valid/ready
//            handshake, scans on start, counts overlapping matches and stops
//            on a match limit or abort.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - pattern_scan_ctrl_if.slave (config handshake, control,
//                   serial bit input, out/busy/done/match_count status)
// Revision : 1.0 - initial release
// ============================================================================
module pattern_scan_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  pattern_scan_ctrl_if.slave  bus
);

  localparam int               LEN_W   = $clog2(MAX_LEN) + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   limit_q;
  logic               cfg_ok_q;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               out_q;
  logic               err_q;

  logic               cfg_fire;
  logic               cfg_legal;
  logic               cfg_take;
  logic               scan_go;
  logic               bit_take;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;
  logic               limit_hit;

  // --------------------------------------------------------------------------
  // Handshake / scan qualifiers and match detection
  // --------------------------------------------------------------------------
  always_comb begin
    cfg_fire  = bus.cfg_valid && (state_q == ST_IDLE);
    cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_MAX);
    cfg_take  = cfg_fire && cfg_legal;
    // A legal config offered together with start is usable by that scan,
    // since the config registers load on the same edge SCAN is entered.
    scan_go   = (state_q == ST_IDLE) && bus.start && (cfg_ok_q || cfg_take);
    // Abort wins over a same-cycle bit; that bit is dropped.
    bit_take  = (state_q == ST_SCAN) && bus.bit_valid && !bus.abort;
  end

  always_comb begin
    hist_d = {hist_q[MAX_LEN-2:0], bus.signal};
    fill_d = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hit       = bit_take && (fill_d >= len_q) &&
                (((hist_d ^ pattern_q) & len_mask) == '0);
    count_d   = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
    limit_hit = hit && (limit_q != '0) && (count_d == limit_q);
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (scan_go) state_d = ST_SCAN;
      ST_SCAN: begin
        if (bus.abort)      state_d = ST_IDLE;
        else if (limit_hit) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.cfg_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      ST_IDLE: bus.cfg_ready = 1'b1;
      ST_SCAN: bus.busy      = 1'b1;
      ST_DONE: bus.done      = 1'b1;
      default: ;
    endcase
  end

  assign bus.out         = out_q;
  assign bus.cfg_err     = err_q;
  assign bus.match_count = count_q;

  // --------------------------------------------------------------------------
  // Configuration and detection datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= '0;
      len_q     <= '0;
      limit_q   <= '0;
      cfg_ok_q  <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      out_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= cfg_fire && !cfg_legal;

      if (cfg_take) begin
        pattern_q <= bus.cfg_pattern;
        len_q     <= bus.cfg_len;
        limit_q   <= bus.cfg_limit;
        cfg_ok_q  <= 1'b1;
      end

      if (scan_go) begin
        hist_q  <= '0;
        fill_q  <= '0;
        count_q <= '0;
        out_q   <= 1'b0;
      end else if (bit_take) begin
        // History is never cleared on a match, so matches may overlap.
        hist_q <= hist_d;
        fill_q <= fill_d;
        out_q  <= hit;
        if (hit) count_q <= count_d;
      end else if (((state_q == ST_SCAN) && bus.abort) || (state_q == ST_DONE)) begin
        // Leaving for IDLE; count and config are kept for inspection.
        out_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_scan_ctrl
// Purpose  : Self-checking bench for pattern_scan_ctrl: vector table, directed
//            multi-cycle sequences and randomized stimulus against a
//            behavioural model built on a queue of received bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_scan_ctrl;

  localparam int ML = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_scan_ctrl_if #(.MAX_LEN(ML), .CNT_W(CW)) bus  ();
  pattern_scan_ctrl_if #(.MAX_LEN(ML), .CNT_W(2))  bus2 ();

  pattern_scan_ctrl #(.MAX_LEN(ML), .CNT_W(CW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pattern_scan_ctrl #(.MAX_LEN(ML), .CNT_W(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: mode 0=idle 1=scan 2=done; bits holds the stream seen
  // since the scan started (only the newest ML bits matter).
  // --------------------------------------------------------------------------
  int       m_mode;
  bit       m_cfgd;
  bit [7:0] m_pat;
  int       m_len;
  int       m_lim;
  bit       m_bits[$];
  bit       m_out;
  int       m_cnt;
  bit       m_err;

  function automatic void model_reset();
    m_mode = 0; m_cfgd = 0; m_pat = 0; m_len = 0; m_lim = 0;
    m_bits.delete(); m_out = 0; m_cnt = 0; m_err = 0;
  endfunction

  function automatic bit stream_ends_with_pattern();
    if (m_bits.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (m_bits[m_bits.size()-1-k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_step();
    bit err_n = 1'b0;
    bit legal;
    bit hit;
    case (m_mode)
      0: begin
        legal = (int'(bus.cfg_len) >= 1) && (int'(bus.cfg_len) <= ML);
        if (bus.cfg_valid) begin
          if (legal) begin
            m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len);
            m_lim = int'(bus.cfg_limit); m_cfgd = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
        if (bus.start && m_cfgd) begin
          m_mode = 1; m_bits.delete(); m_cnt = 0; m_out = 0;
        end
      end
      1: begin
        if (bus.abort) begin
          m_mode = 0; m_out = 0;
        end else if (bus.bit_valid) begin
          m_bits.push_back(bus.signal);
          if (m_bits.size() > ML) void'(m_bits.pop_front());
          hit   = stream_ends_with_pattern();
          m_out = hit;
          if (hit) begin
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            if (m_lim != 0 && m_cnt == m_lim) m_mode = 2;
          end
        end
      end
      default: begin
        m_mode = 0; m_out = 0;
      end
    endcase
    m_err = err_n;
  endfunction

  task automatic cmp_model(input string nm);
    chk({nm, "_out"},   bus.out,         m_out);
    chk({nm, "_busy"},  bus.busy,        m_mode == 1);
    chk({nm, "_done"},  bus.done,        m_mode == 2);
    chk({nm, "_ready"}, bus.cfg_ready,   m_mode == 0);
    chk({nm, "_err"},   bus.cfg_err,     m_err);
    chk({nm, "_count"}, bus.match_count, m_cnt);
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit cv, input int pat, input int len, input int lim,
                       input bit st, input bit ab, input bit bv, input bit sg);
    bus.cfg_valid   = cv;
    bus.cfg_pattern = 8'(pat);
    bus.cfg_len     = 4'(len);
    bus.cfg_limit   = 8'(lim);
    bus.start       = st;
    bus.abort       = ab;
    bus.bit_valid   = bv;
    bus.signal      = sg;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // --------------------------------------------------------------------------
  // Vector table
  // --------------------------------------------------------------------------
  typedef struct {
    bit cv; int pat; int len; int lim; bit st; bit ab; bit bv; bit sg;
    bit eo; bit eb; bit ed; bit er; bit ee; int ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit cv, int pat, int len, int lim, bit st, bit ab,
                              bit bv, bit sg, bit eo, bit eb, bit ed, bit er,
                              bit ee, int ec);
    vec_t v;
    v.cv = cv; v.pat = pat; v.len = len; v.lim = lim; v.st = st; v.ab = ab;
    v.bv = bv; v.sg = sg; v.eo = eo; v.eb = eb; v.ed = ed; v.er = er;
    v.ee = ee; v.ec = ec;
    return v;
  endfunction

  function automatic void bit_row(bit sg, bit eo, int ec);
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, sg, eo, 1, 0, 0, 0, ec));
  endfunction

  function automatic void gap_row(bit eo, int ec);
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, eo, 1, 0, 0, 0, ec));
  endfunction

  function automatic void build_table();
    // 1011, len 4, unlimited: stream 1,0,1,1,0,1,1 back to back
    vecs.push_back(mk(1, 'hB, 4, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    bit_row(1, 0, 0); bit_row(0, 0, 0); bit_row(1, 0, 0); bit_row(1, 1, 1);
    bit_row(0, 0, 1); bit_row(1, 0, 1); bit_row(1, 1, 2);
    gap_row(1, 2);
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 2));
    // same pattern, limit 2, idle gaps between bits
    vecs.push_back(mk(1, 'hB, 4, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    bit_row(1, 0, 0); gap_row(0, 0); bit_row(0, 0, 0); gap_row(0, 0);
    bit_row(1, 0, 0); gap_row(0, 0); bit_row(1, 1, 1); gap_row(1, 1);
    bit_row(0, 0, 1); gap_row(0, 1); bit_row(1, 0, 1); gap_row(0, 1);
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    // len 1, pattern 1: every 1 matches, out stays high
    vecs.push_back(mk(1, 'h1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    bit_row(1, 1, 1); bit_row(1, 1, 2); bit_row(1, 1, 3);
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3));
    // rejected len 0 leaves len 1 / pattern 1 in place
    vecs.push_back(mk(1, 'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    bit_row(1, 1, 1);
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1));
  endfunction

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    idle();
    bus2.cfg_valid = 0; bus2.cfg_pattern = 0; bus2.cfg_len = 0; bus2.cfg_limit = 0;
    bus2.start = 0; bus2.abort = 0; bus2.bit_valid = 0; bus2.signal = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    cyc();
    chk("rst_ready", bus.cfg_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out", bus.out, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.cfg_err, 0);
    chk("rst_count", bus.match_count, 0);

    // illegal lengths, then start with nothing configured
    drive(1, 'h5, 0, 0, 0, 0, 0, 0); cyc();
    chk("len0_err", bus.cfg_err, 1);
    idle(); cyc();
    chk("err_clear", bus.cfg_err, 0);
    drive(1, 'h5, 9, 0, 0, 0, 0, 0); cyc();
    chk("len9_err", bus.cfg_err, 1);
    drive(0, 0, 0, 0, 1, 0, 0, 0); cyc();
    chk("nocfg_busy", bus.busy, 0);
    cyc();
    chk("nocfg_busy2", bus.busy, 0);
    idle(); cyc();
    cmp_model("pre");

    // table
    build_table();
    foreach (vecs[i]) begin
      drive(vecs[i].cv, vecs[i].pat, vecs[i].len, vecs[i].lim,
            vecs[i].st, vecs[i].ab, vecs[i].bv, vecs[i].sg);
      cyc();
      chk($sformatf("v%0d_out", i),   bus.out,         vecs[i].eo);
      chk($sformatf("v%0d_busy", i),  bus.busy,        vecs[i].eb);
      chk($sformatf("v%0d_done", i),  bus.done,        vecs[i].ed);
      chk($sformatf("v%0d_ready", i), bus.cfg_ready,   vecs[i].er);
      chk($sformatf("v%0d_err", i),   bus.cfg_err,     vecs[i].ee);
      chk($sformatf("v%0d_count", i), bus.match_count, vecs[i].ec);
    end
    idle(); cyc();

    // abort together with the bit that would complete a match
    drive(1, 'hB, 4, 0, 1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 1); cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 1); cyc();
    drive(0, 0, 0, 0, 0, 1, 1, 1); cyc();
    chk("abrt_count", bus.match_count, 0);
    chk("abrt_out", bus.out, 0);
    chk("abrt_busy", bus.busy, 0);
    chk("abrt_ready", bus.cfg_ready, 1);
    idle(); cyc();

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      int len;
      if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15);
      else                           len = $urandom_range(1, 5);
      drive($urandom_range(0, 9) == 0, $urandom, len, $urandom_range(0, 3),
            $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      cyc();
      cmp_model("rnd");
    end
    idle(); cyc();
    cmp_model("rnd_end");

    // narrow counter saturates at 3
    bus2.cfg_valid = 1; bus2.cfg_pattern = 0; bus2.cfg_len = 1; bus2.cfg_limit = 0;
    bus2.start = 1;
    cyc();
    chk("n2_busy", bus2.busy, 1);
    bus2.cfg_valid = 0; bus2.start = 0; bus2.bit_valid = 1; bus2.signal = 0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk($sformatf("n2_cnt%0d", k), bus2.match_count, (k < 3) ? k : 3);
      chk($sformatf("n2_out%0d", k), bus2.out, 1);
    end
    bus2.bit_valid = 0;

    // asynchronous reset in the middle of a scan with matches counted
    drive(1, 'h1, 1, 0, 1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 1); cyc(); cyc();
    chk("pre_rst_count", bus.match_count, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", bus.out, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_ready", bus.cfg_ready, 1);
    chk("arst_count", bus.match_count, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_err", bus.cfg_err, 0);
    chk("arst_n2_count", bus2.match_count, 0);
    chk("arst_n2_busy", bus2.busy, 0);
    model_reset();
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 1, 0, 0, 0); cyc();
    chk("cfg_lost_busy", bus.busy, 0);
    idle(); cyc();
    cmp_model("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
